// File: rtl/multi_bit_hs_tx_pkg.sv
// Shared definitions for the multi-bit req/ack handshake initiator.
// Contents: FSM state encoding and the minimum legal synchronizer depth.
package multi_bit_hs_tx_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/multi_bit_hs_tx_sync.sv
// Single-bit multi-flop synchronizer for the returned ack toggle.
// Ports: clk, rst_n (async active-low, chain resets to 0), d (async input),
//        q (output of the last stage).
module multi_bit_hs_tx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/multi_bit_hs_tx.sv
// Source side of a multi-bit req/ack CDC handshake: captures a word, holds it
// on tx_data, flips tx_req and waits for the synchronized tx_ack to match.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/din upstream port;
//        tx_data/tx_req to destination, tx_ack back from it; done pulse,
//        busy level, timeout_err pulse, err_sticky flag with err_clr clear.
module multi_bit_hs_tx
  import multi_bit_hs_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  input  logic                  tx_ack,
  output logic                  done,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int unsigned CNT_W =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("SYNC_STAGES must be at least SYNC_STAGES_MIN");
  end

  state_e state, state_nxt;
  logic   ack_s;
  logic   accept_c;
  logic   match_c;

  multi_bit_hs_tx_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_ack),
    .q     (ack_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state; ack toggles seen while idle are spurious and ignored
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    match_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_s == tx_req) begin
          match_c   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Held word, request toggle and handshake status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_req   <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= match_c;
      in_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt == ST_WAIT_ACK);
      if (accept_c) begin
        tx_data <= din;
        tx_req  <= ~tx_req;
      end
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic             tmo_c;

    // Counter saturates past CNT_LAST so the error fires only once per transfer;
    // a match in the same cycle takes priority over the timeout.
    assign tmo_c = (state == ST_WAIT_ACK) && !match_c && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt         <= '0;
        timeout_err <= 1'b0;
        err_sticky  <= 1'b0;
      end else begin
        timeout_err <= tmo_c;
        if (accept_c)                               cnt <= '0;
        else if (state == ST_WAIT_ACK && cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
        if (tmo_c)        err_sticky <= 1'b1;
        else if (err_clr) err_sticky <= 1'b0;
      end
    end
  end else begin : g_no_tmo
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign timeout_err    = 1'b0;
    assign err_sticky     = 1'b0;
  end

endmodule

// File: tb/tb_multi_bit_hs_tx.sv
// Directed self-checking bench for multi_bit_hs_tx (TIMEOUT_CYCLES=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_bit_hs_tx;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] din;
  logic [DW-1:0] tx_data;
  logic          tx_req;
  logic          tx_ack;
  logic          done;
  logic          busy;
  logic          timeout_err;
  logic          err_sticky;
  logic          err_clr;

  int passed = 0;
  int total  = 0;
  int dones  = 0;

  logic [DW-1:0] words [0:2];
  logic          exp_req;

  multi_bit_hs_tx #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_sticky  (err_sticky),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    tx_ack   = 1'b0;
    err_clr  = 1'b0;
    din      = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk_w({tag, "_tx_data"},  tx_data,     8'h00);
    chk_b({tag, "_tx_req"},   tx_req,      1'b0);
    chk_b({tag, "_in_ready"}, in_ready,    1'b1);
    chk_b({tag, "_done"},     done,        1'b0);
    chk_b({tag, "_busy"},     busy,        1'b0);
    chk_b({tag, "_tmo"},      timeout_err, 1'b0);
    chk_b({tag, "_sticky"},   err_sticky,  1'b0);
  endtask

  initial begin
    words[0] = 8'h01;
    words[1] = 8'h02;
    words[2] = 8'h03;

    // Reset state
    do_reset();
    chk_reset_vals("rst");

    // 1: first word accepted
    in_valid = 1'b1;
    din      = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    chk_w("t1_tx_data",  tx_data,  8'hA5);
    chk_b("t1_tx_req",   tx_req,   1'b1);
    chk_b("t1_in_ready", in_ready, 1'b0);
    chk_b("t1_busy",     busy,     1'b1);

    // 2: ack returns 5 cycles after tx_req
    repeat (4) begin
      @(negedge clk);
      chk_b("t2_wait_done", done, 1'b0);
      chk_w("t2_hold_data", tx_data, 8'hA5);
    end
    tx_ack = 1'b1;
    repeat (SYNC) begin
      @(negedge clk);
      chk_b("t2_sync_done", done, 1'b0);
      chk_b("t2_sync_busy", busy, 1'b1);
    end
    @(negedge clk);
    chk_b("t2_done",     done,     1'b1);
    chk_b("t2_in_ready", in_ready, 1'b1);
    chk_b("t2_busy",     busy,     1'b0);
    @(negedge clk);
    chk_b("t2_done_pulse", done, 1'b0);

    // 3: back-to-back words with in_valid held
    do_reset();
    exp_req  = 1'b0;
    in_valid = 1'b1;
    din      = words[0];
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      exp_req = ~exp_req;
      chk_b("t3_tx_req",  tx_req,  exp_req);
      chk_w("t3_tx_data", tx_data, words[w]);
      chk_b("t3_busy",    busy,    1'b1);
      if (w < 2) din = words[w+1];
      else       in_valid = 1'b0;
      tx_ack = exp_req;
      repeat (SYNC) begin
        @(negedge clk);
        chk_w("t3_hold_data", tx_data, words[w]);
        chk_b("t3_wait_done", done, 1'b0);
      end
      @(negedge clk);
      chk_b("t3_done",     done,     1'b1);
      chk_b("t3_in_ready", in_ready, 1'b1);
      if (done === 1'b1) dones = dones + 1;
    end
    @(negedge clk);
    chk_b("t3_idle_done", done, 1'b0);
    chk_w("t3_done_count", 8'(dones), 8'd3);

    // 4: no ack -> timeout after 16 WAIT_ACK cycles (tx_req currently 1, tx_ack 1)
    in_valid = 1'b1;
    din      = 8'hC3;
    @(negedge clk);
    in_valid = 1'b0;
    chk_b("t4_tx_req", tx_req, 1'b0);
    repeat (TMO - 1) @(negedge clk);
    chk_b("t4_pre_tmo", timeout_err, 1'b0);
    @(negedge clk);
    chk_b("t4_tmo",      timeout_err, 1'b1);
    chk_b("t4_sticky",   err_sticky,  1'b1);
    chk_b("t4_busy_tmo", busy,        1'b1);
    @(negedge clk);
    chk_b("t4_tmo_pulse", timeout_err, 1'b0);
    chk_w("t4_hold_data", tx_data,     8'hC3);
    chk_b("t4_hold_req",  tx_req,      1'b0);
    tx_ack = 1'b0;
    repeat (SYNC) @(negedge clk);
    @(negedge clk);
    chk_b("t4_late_done",  done,        1'b1);
    chk_b("t4_sticky_hold", err_sticky, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_b("t4_sticky_clr", err_sticky, 1'b0);

    // 5: ack seen exactly on the timeout cycle wins
    in_valid = 1'b1;
    din      = 8'hD2;
    @(negedge clk);
    in_valid = 1'b0;
    chk_b("t5_tx_req", tx_req, 1'b1);
    repeat (TMO - 1 - SYNC) @(negedge clk);
    tx_ack = 1'b1;
    repeat (SYNC) begin
      @(negedge clk);
      chk_b("t5_wait_done", done, 1'b0);
    end
    @(negedge clk);
    chk_b("t5_done",   done,        1'b1);
    chk_b("t5_no_tmo", timeout_err, 1'b0);
    chk_b("t5_sticky", err_sticky,  1'b0);

    // 5b: spurious ack toggle while idle
    tx_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk_b("t5_spur_done",  done,     1'b0);
      chk_b("t5_spur_ready", in_ready, 1'b1);
      chk_b("t5_spur_busy",  busy,     1'b0);
    end

    // 6: asynchronous reset in the middle of WAIT_ACK
    do_reset();
    in_valid = 1'b1;
    din      = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    chk_w("t6_tx_data", tx_data, 8'h5A);
    chk_b("t6_tx_req",  tx_req,  1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk_b("t6_no_done", done, 1'b0);
      chk_b("t6_idle",    in_ready, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
